// File: rtl/dp_ram_b_arbiter.sv
// Two-requester arbiter for the shared read/write port B of the dual-port RAM, with a lock for requester 1.
// Define DP_RAM_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise m0 has fixed priority over m1.
module dp_ram_b_arbiter #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  m0_req_i,
    output logic                  m0_gnt_o,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic                  m0_we_i,
    input  logic [3:0]            m0_be_i,
    input  logic [31:0]           m0_wdata_i,
    output logic                  m0_rvalid_o,
    output logic [31:0]           m0_rdata_o,
    input  logic                  m1_req_i,
    output logic                  m1_gnt_o,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic                  m1_we_i,
    input  logic [3:0]            m1_be_i,
    input  logic [31:0]           m1_wdata_i,
    output logic                  m1_rvalid_o,
    output logic [31:0]           m1_rdata_o,
    input  logic                  m1_lock_i,
    output logic                  m1_locked_o,
    output logic                  ram_en_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic                  ram_we_o,
    output logic [3:0]            ram_be_o,
    output logic [31:0]           ram_wdata_o,
    input  logic [31:0]           ram_rdata_i
);

    localparam logic [0:0] UNLOCKED = 1'b0;
    localparam logic [0:0] LOCKED   = 1'b1;

    logic [1:0]            req;
    logic [1:0]            gnt;
    logic [1:0]            rvalid;
    logic [ADDR_WIDTH-1:0] addr  [2];
    logic                  we    [2];
    logic [3:0]            be    [2];
    logic [31:0]           wdata [2];
    logic [31:0]           rdata [2];

    logic [0:0] lock_state_reg;
    logic [0:0] lock_state_next;
    logic       resp_valid_reg;
    logic       resp_owner_reg;
    logic       resp_we_reg;

    assign req      = {m1_req_i, m0_req_i};
    assign addr[0]  = m0_addr_i;
    assign addr[1]  = m1_addr_i;
    assign we[0]    = m0_we_i;
    assign we[1]    = m1_we_i;
    assign be[0]    = m0_be_i;
    assign be[1]    = m1_be_i;
    assign wdata[0] = m0_wdata_i;
    assign wdata[1] = m1_wdata_i;

`ifdef DP_RAM_ARB_ROUND_ROBIN_EN
    // prio_reg names the requester that wins the next contention cycle
    logic prio_reg;
    logic prio_next;

    always_comb begin
        prio_next = prio_reg;
        if (gnt[0]) begin
            prio_next = 1'b1;
        end else if (gnt[1]) begin
            prio_next = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            prio_reg <= 1'b0;
        end else begin
            prio_reg <= prio_next;
        end
    end
`endif

    always_comb begin
        gnt = 2'b00;
        if (rst_ni) begin
            if (lock_state_reg == LOCKED) begin
                gnt[1] = req[1];
            end else begin
`ifdef DP_RAM_ARB_ROUND_ROBIN_EN
                if (&req) begin
                    gnt[0] = ~prio_reg;
                    gnt[1] = prio_reg;
                end else begin
                    gnt = req;
                end
`else
                gnt[0] = req[0];
                gnt[1] = req[1] & ~req[0];
`endif
            end
        end
    end

    always_comb begin
        ram_en_o    = 1'b0;
        ram_addr_o  = '0;
        ram_we_o    = 1'b0;
        ram_be_o    = 4'b0000;
        ram_wdata_o = 32'd0;
        if (|gnt) begin
            ram_en_o    = 1'b1;
            ram_addr_o  = addr[gnt[1]];
            ram_we_o    = we[gnt[1]];
            ram_be_o    = be[gnt[1]];
            ram_wdata_o = wdata[gnt[1]];
        end
    end

    always_comb begin
        lock_state_next = lock_state_reg;
        case (lock_state_reg)
            UNLOCKED: if (m1_lock_i && gnt[1]) lock_state_next = LOCKED;
            LOCKED:   if (!m1_lock_i) lock_state_next = UNLOCKED;
            default:  lock_state_next = UNLOCKED;
        endcase
    end

    // The response register is independent of the lock, so an issued response is always delivered
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lock_state_reg <= UNLOCKED;
            resp_valid_reg <= 1'b0;
            resp_owner_reg <= 1'b0;
            resp_we_reg    <= 1'b0;
        end else begin
            lock_state_reg <= lock_state_next;
            resp_valid_reg <= |gnt;
            resp_owner_reg <= gnt[1];
            resp_we_reg    <= ram_we_o;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_resp
            assign rvalid[gi] = resp_valid_reg && (resp_owner_reg == 1'(gi));
            assign rdata[gi]  = (rvalid[gi] && !resp_we_reg) ? ram_rdata_i : 32'd0;
        end
    endgenerate

    assign m0_gnt_o    = gnt[0];
    assign m1_gnt_o    = gnt[1];
    assign m0_rvalid_o = rvalid[0];
    assign m1_rvalid_o = rvalid[1];
    assign m0_rdata_o  = rdata[0];
    assign m1_rdata_o  = rdata[1];
    assign m1_locked_o = (lock_state_reg == LOCKED);

endmodule

// File: tb/tb_dp_ram_b_arbiter.sv
// Bench for dp_ram_b_arbiter: bench-side RAM, behavioural reference model checked every cycle, directed and random stimulus.
// Honours DP_RAM_ARB_ROUND_ROBIN_EN the same way as the design.
module tb_dp_ram_b_arbiter;
    localparam int AW = 8;
`ifdef DP_RAM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_req, m0_gnt, m0_we, m0_rvalid;
    logic [AW-1:0] m0_addr;
    logic [3:0]    m0_be;
    logic [31:0]   m0_wdata, m0_rdata;
    logic          m1_req, m1_gnt, m1_we, m1_rvalid, m1_lock, m1_locked;
    logic [AW-1:0] m1_addr;
    logic [3:0]    m1_be;
    logic [31:0]   m1_wdata, m1_rdata;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [3:0]    ram_be;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    always #5 clk = ~clk;

    dp_ram_b_arbiter #(.ADDR_WIDTH(AW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_req_i(m0_req), .m0_gnt_o(m0_gnt), .m0_addr_i(m0_addr), .m0_we_i(m0_we),
        .m0_be_i(m0_be), .m0_wdata_i(m0_wdata), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
        .m1_req_i(m1_req), .m1_gnt_o(m1_gnt), .m1_addr_i(m1_addr), .m1_we_i(m1_we),
        .m1_be_i(m1_be), .m1_wdata_i(m1_wdata), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
        .m1_lock_i(m1_lock), .m1_locked_o(m1_locked),
        .ram_en_o(ram_en), .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_be_o(ram_be),
        .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
    );

    // Bench RAM driven by the DUT's port B, plus an independent reference copy used by the model
    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]     = {4{8'(i)}};
            ref_mem[i] = {4{8'(i)}};
        end
        mem[4]     = 32'h44332211;
        ref_mem[4] = 32'h44332211;
        ram_rdata  = 32'd0;
    end

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be[b]) mem[ram_addr[7:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end else begin
                ram_rdata <= mem[ram_addr[7:2]];
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: lock flag, favoured requester, and the one pending response
    bit          armed    = 1'b0;
    bit          m_locked = 1'b0;
    int          m_prio   = 0;
    bit          m_rv     = 1'b0;
    int          m_owner  = 0;
    logic [31:0] m_rdata  = 32'd0;

    function automatic int winner();
        if (!rst_n) return -1;
        if (m_locked) return m1_req ? 1 : -1;
        if (m0_req && m1_req) return RR ? m_prio : 0;
        if (m0_req) return 0;
        if (m1_req) return 1;
        return -1;
    endfunction

    always @(posedge clk) begin
        int w;
        logic          a_we;
        logic [AW-1:0] a_addr;
        logic [3:0]    a_be;
        logic [31:0]   a_wd;
        w = winner();
        if (!rst_n) begin
            m_locked = 1'b0;
            m_prio   = 0;
            m_rv     = 1'b0;
            armed    = 1'b1;
        end else begin
            m_rv    = (w >= 0);
            m_owner = w;
            if (w >= 0) begin
                a_we   = (w == 0) ? m0_we    : m1_we;
                a_addr = (w == 0) ? m0_addr  : m1_addr;
                a_be   = (w == 0) ? m0_be    : m1_be;
                a_wd   = (w == 0) ? m0_wdata : m1_wdata;
                if (a_we) begin
                    m_rdata = 32'd0;
                    for (int b = 0; b < 4; b++)
                        if (a_be[b]) ref_mem[a_addr[7:2]][8*b +: 8] = a_wd[8*b +: 8];
                end else begin
                    m_rdata = ref_mem[a_addr[7:2]];
                end
                m_prio = 1 - w;
            end
            if (m_locked) m_locked = m1_lock;
            else          m_locked = m1_lock && (w == 1);
        end
    end

    always @(negedge clk) begin
        int w;
        if (armed) begin
            w = winner();
            chk("m_gnt0", 32'(m0_gnt), 32'(w == 0));
            chk("m_gnt1", 32'(m1_gnt), 32'(w == 1));
            chk("m_ram_en", 32'(ram_en), 32'(w >= 0));
            if (w == 0) begin
                chk("m_ram_addr", 32'(ram_addr), 32'(m0_addr));
                chk("m_ram_we", 32'(ram_we), 32'(m0_we));
                if (m0_we) chk("m_ram_wr", {ram_be, ram_wdata[27:0]}, {m0_be, m0_wdata[27:0]});
            end else if (w == 1) begin
                chk("m_ram_addr", 32'(ram_addr), 32'(m1_addr));
                chk("m_ram_we", 32'(ram_we), 32'(m1_we));
                if (m1_we) chk("m_ram_wr", {ram_be, ram_wdata[27:0]}, {m1_be, m1_wdata[27:0]});
            end else begin
                chk("m_ram_idle", {27'd0, ram_we, ram_be}, 32'd0);
            end
            chk("m_rvalid0", 32'(m0_rvalid), 32'(m_rv && m_owner == 0));
            chk("m_rvalid1", 32'(m1_rvalid), 32'(m_rv && m_owner == 1));
            chk("m_rdata0", m0_rdata, (m_rv && m_owner == 0) ? m_rdata : 32'd0);
            chk("m_rdata1", m1_rdata, (m_rv && m_owner == 1) ? m_rdata : 32'd0);
            chk("m_locked", 32'(m1_locked), 32'(m_locked));
        end
    end

    task automatic idle();
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_be = 4'hF; m0_wdata = 32'd0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_be = 4'hF; m1_wdata = 32'd0;
        m1_lock = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int g;
        rst_n = 1'b0;
        idle();
        m0_req = 1'b1;
        cyc();
        cyc();
        @(negedge clk);
        $display("txn reset: m0_req held during reset");
        chk("rst_gnt0", 32'(m0_gnt), 32'd0);
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        chk("rst_rvalid0", 32'(m0_rvalid), 32'd0);
        chk("rst_locked", 32'(m1_locked), 32'd0);
        cyc(); rst_n = 1'b1; idle();

        cyc(); m0_req = 1'b1; m0_addr = 8'h10;
        @(negedge clk);
        $display("txn single read: m0 reads 0x10");
        chk("rd_gnt0", 32'(m0_gnt), 32'd1);
        chk("rd_ram_addr", 32'(ram_addr), 32'h10);
        cyc(); idle();
        @(negedge clk);
        chk("rd_rvalid0", 32'(m0_rvalid), 32'd1);
        chk("rd_rdata0", m0_rdata, 32'h44332211);
        chk("rd_rvalid1", 32'(m1_rvalid), 32'd0);

        mem[8] = 32'd0; ref_mem[8] = 32'd0;
        cyc(); m1_req = 1'b1; m1_we = 1'b1; m1_addr = 8'h20; m1_be = 4'b0011; m1_wdata = 32'hDEADBEEF;
        @(negedge clk);
        $display("txn write: m1 writes 0xDEADBEEF be=0011 to 0x20");
        chk("wr_gnt1", 32'(m1_gnt), 32'd1);
        cyc(); m1_we = 1'b0;
        @(negedge clk);
        $display("txn read: m1 reads 0x20");
        chk("wr_rvalid1", 32'(m1_rvalid), 32'd1);
        chk("wr_rdata1", m1_rdata, 32'd0);
        cyc(); idle();
        @(negedge clk);
        chk("wrd_rdata1", m1_rdata, 32'h0000BEEF);

        // Favoured requester is m0 here: last grant went to m1
        for (int i = 0; i < 4; i++) begin
            cyc(); m0_req = 1'b1; m1_req = 1'b1; m0_addr = 8'(4 * i); m1_addr = 8'(8'h40 + 4 * i);
            @(negedge clk);
            g = RR ? (i % 2) : 0;
            $display("txn contention %0d: both request", i);
            chk("ct_gnt0", 32'(m0_gnt), 32'(g == 0));
            chk("ct_gnt1", 32'(m1_gnt), 32'(g == 1));
        end
        cyc(); idle();
        @(negedge clk);
        chk("ct_last_rvalid0", 32'(m0_rvalid), RR ? 32'd0 : 32'd1);
        chk("ct_last_rvalid1", 32'(m1_rvalid), RR ? 32'd1 : 32'd0);

        cyc(); m1_req = 1'b1; m1_lock = 1'b1; m1_addr = 8'h30;
        @(negedge clk);
        $display("txn lock: m1 acquires lock");
        chk("lk_gnt1", 32'(m1_gnt), 32'd1);
        chk("lk_locked_pre", 32'(m1_locked), 32'd0);
        for (int k = 1; k < 3; k++) begin
            cyc(); m0_req = 1'b1; m1_req = 1'b1; m1_lock = 1'b1; m1_addr = 8'(8'h30 + 4 * k);
            @(negedge clk);
            $display("txn lock: m1 locked access %0d", k);
            chk("lk_gnt0", 32'(m0_gnt), 32'd0);
            chk("lk_gnt1b", 32'(m1_gnt), 32'd1);
            chk("lk_locked", 32'(m1_locked), 32'd1);
        end
        cyc(); m1_req = 1'b0; m1_lock = 1'b0;
        @(negedge clk);
        chk("lk_drop_gnt0", 32'(m0_gnt), 32'd0);
        chk("lk_drop_locked", 32'(m1_locked), 32'd1);
        cyc();
        @(negedge clk);
        $display("txn lock released: m0 granted");
        chk("lk_after_gnt0", 32'(m0_gnt), 32'd1);
        chk("lk_after_locked", 32'(m1_locked), 32'd0);
        cyc(); idle();

        cyc(); m1_req = 1'b1; m1_addr = 8'h08;
        cyc(); m0_req = 1'b1; m0_addr = 8'h0C; m1_req = 1'b1; m1_we = 1'b1; m1_addr = 8'h3C; m1_wdata = 32'h12345678;
        @(negedge clk);
        $display("txn withdrawn: m1 write loses and is withdrawn");
        chk("wd_gnt0", 32'(m0_gnt), 32'd1);
        chk("wd_gnt1", 32'(m1_gnt), 32'd0);
        chk("wd_ram_addr", 32'(ram_addr), 32'h0C);
        cyc(); idle();
        @(negedge clk);
        chk("wd_rvalid1", 32'(m1_rvalid), 32'd0);
        chk("wd_rvalid0", 32'(m0_rvalid), 32'd1);
        cyc(); m0_req = 1'b1; m0_addr = 8'h3C;
        cyc(); idle();
        @(negedge clk);
        chk("wd_mem_untouched", m0_rdata, 32'h0F0F0F0F);

        cyc(); m0_req = 1'b1; m0_addr = 8'h10;
        @(negedge clk);
        $display("txn reset mid-operation: m0 read then reset");
        chk("rm_gnt0", 32'(m0_gnt), 32'd1);
        cyc(); rst_n = 1'b0;
        @(negedge clk);
        chk("rm_ram_en", 32'(ram_en), 32'd0);
        chk("rm_gnt0_rst", 32'(m0_gnt), 32'd0);
        cyc();
        @(negedge clk);
        chk("rm_rvalid0", 32'(m0_rvalid), 32'd0);
        chk("rm_rdata0", m0_rdata, 32'd0);
        chk("rm_locked", 32'(m1_locked), 32'd0);
        cyc(); rst_n = 1'b1; idle();

        for (int n = 0; n < 600; n++) begin
            cyc();
            rst_n    = ($urandom_range(0, 79) != 0);
            m0_req   = $urandom_range(0, 2) != 0;
            m0_we    = $urandom_range(0, 2) == 0;
            m0_addr  = {6'($urandom_range(0, 63)), 2'b00};
            m0_be    = 4'($urandom);
            m0_wdata = $urandom;
            m1_req   = $urandom_range(0, 1) != 0;
            m1_we    = $urandom_range(0, 2) == 0;
            m1_addr  = {6'($urandom_range(0, 63)), 2'b00};
            m1_be    = 4'($urandom);
            m1_wdata = $urandom;
            m1_lock  = $urandom_range(0, 3) == 0;
        end
        $display("txn random: 600 cycles of random traffic");
        cyc(); idle();
        cyc();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dp_ram_b_arbiter.md
# dp_ram_b_arbiter

Two-requester arbiter that shares the single read/write data port (port B) of the testbench dual-port RAM between the core data interface (requester 0) and a testbench-side master (requester 1, e.g. a loader or virtual peripheral). It uses an OBI-style req/gnt/rvalid handshake on each requester side and drives the RAM port B signals directly. It tracks the one-cycle RAM read latency so that each response is routed back to the requester that issued it. A lock mechanism lets requester 1 perform uninterrupted multi-access sequences.

## Interface
- ADDR_WIDTH, 8: RAM byte-address width; matches the RAM instance.

- clk_i  in  1  clock; all logic on posedge
- rst_ni  in  1  synchronous active-low reset
- m0_req_i / m1_req_i  in  1  access request
- m0_gnt_o / m1_gnt_o  out  1  request accepted this cycle (combinational from req)
- m0_addr_i / m1_addr_i  in  ADDR_WIDTH  byte address
- m0_we_i / m1_we_i  in  1  1 = write
- m0_be_i / m1_be_i  in  4  byte enables
- m0_wdata_i / m1_wdata_i  in  32  write data
- m0_rvalid_o / m1_rvalid_o  out  1  response valid (reads and writes)
- m0_rdata_o / m1_rdata_o  out  32  read data; 0 on write responses
- m1_lock_i  in  1  requester 1 requests exclusive ownership
- m1_locked_o  out  1  lock currently held by requester 1
- ram_en_o  out  1  RAM port B enable
- ram_addr_o  out  ADDR_WIDTH  RAM port B address
- ram_we_o  out  1  RAM port B write enable
- ram_be_o  out  4  RAM port B byte enables
- ram_wdata_o  out  32  RAM port B write data
- ram_rdata_i  in  32  RAM port B read data, valid the cycle after a granted read

## Operation
- At most one grant per cycle; mX_gnt_o = 1 only if mX_req_i = 1 and X wins arbitration.
- On grant, the winner's addr/we/be/wdata drive the ram_* outputs and ram_en_o = 1 in the same cycle. With no grant, ram_en_o = 0, and ram_we_o and ram_be_o = 0.
- Response register: on grant, store owner, we, and valid. The next cycle, the owner's rvalid_o = 1; its rdata_o = ram_rdata_i for a read and 0 for a write. The non-owner's rvalid_o = 0 and rdata_o = 0.
- Lock FSM, states UNLOCKED and LOCKED:
  - UNLOCKED -> LOCKED when m1_lock_i = 1 and m1 is granted that cycle.
  - LOCKED -> UNLOCKED when m1_lock_i = 0 (sampled at the clock edge).
  - In LOCKED, m0 is never granted and m1_locked_o = 1.
  - Lock never pre-empts an already issued response.
- Arbitration policy is set by the Configuration section.
- Requests are not required to be held until granted; an ungranted request may be withdrawn.

## Timing
- Reset (rst_ni = 0 at posedge):
  - FSM goes to UNLOCKED; round-robin pointer points to m0.
  - Response register is cleared, so any pending response is dropped and both rvalid_o = 0 from the next cycle.
  - Registered outputs after reset: m1_locked_o = 0, m0/m1_rvalid_o = 0, m0/m1_rdata_o = 0.
  - The combinational gnt/ram_* outputs are forced to 0 while rst_ni = 0.
- Grant latency: 0 cycles (combinational). Response latency: exactly 1 cycle after grant.
- Throughput: one access per cycle. Back-to-back grants to the same or alternating requesters are allowed with no bubble.
- Same-cycle event: response for access N and grant of access N+1 coincide. This is legal and independent.

## Configuration
- DP_RAM_ARB_ROUND_ROBIN_EN defined:
  - Round-robin arbitration; the last-granted requester has lowest priority on the next contention cycle.
  - The pointer updates only on cycles with a grant.
- DP_RAM_ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority, m0 over m1; no pointer state.
  - m1 can starve under continuous m0 traffic unless it holds the lock.

## Test plan
- Single read: preload mem[0x10..0x13] = 0x44332211; m0 reads 0x10. Required: m0_gnt_o = 1 in cycle T; m0_rvalid_o = 1 with m0_rdata_o = 0x44332211 in T+1; m1_rvalid_o = 0.
- Write then read: m1 writes 0xDEADBEEF with be = 4'b0011 to 0x20 (old value 0); the next cycle m1 reads 0x20. Required: write response has rdata = 0; read returns 0x0000BEEF.
- Contention, both req every cycle for 4 cycles:
  - With the macro: grants alternate m0, m1, m0, m1.
  - Without the macro: m0 is granted on all 4 cycles.
  - In both cases each rvalid goes only to the owner.
- Lock: m1 asserts lock and req while m0 requests continuously, holds lock for 3 accesses, then drops it. Required: m1_locked_o = 1 for those cycles; m0_gnt_o = 0 until the cycle after m1_lock_i is deasserted, after which m0 is granted.
- Reset mid-operation: grant an m0 read in cycle T, then assert rst_ni = 0 at T+1. Required: m0_rvalid_o = 0 after reset; m1_locked_o = 0; ram_en_o = 0 while in reset.
- Withdrawn request: m1 req for 1 cycle while m0 wins (fixed priority). Required: no m1 grant, no m1 response, no RAM access from m1.
